// File: rtl/plab5_mcore_mem_bank_pkg.sv
// plab5_mcore_mem_bank_pkg: shared types, field layout and helpers for the domain-tagged memory bank
package plab5_mcore_mem_bank_pkg;
  typedef enum logic [2:0] {MEM_READ = 3'd0, MEM_WRITE = 3'd1, MEM_INIT = 3'd2} mem_type_e;
  typedef enum logic {DOM_LOW = 1'b0, DOM_HIGH = 1'b1} mem_domain_e;
  localparam int TYPE_NBITS     = 3;
  localparam int LEN_NBITS      = 2;
  localparam int BYTE_OFF_NBITS = 2;
  localparam int CTRL_LEN_LSB   = 0;
  localparam int CTRL_ADDR_LSB  = LEN_NBITS;
  function automatic int rqc_nbits(int o, int a);
    return TYPE_NBITS + o + a + LEN_NBITS;
  endfunction
  function automatic int rsc_nbits(int o);
    return TYPE_NBITS + o + LEN_NBITS;
  endfunction
  function automatic logic [31:0] len_mask(logic [1:0] len);
    return len == 2'd0 ? 32'hFFFF_FFFF :
           len == 2'd1 ? 32'h0000_00FF :
           len == 2'd2 ? 32'h0000_FFFF : 32'h00FF_FFFF;
  endfunction
endpackage

// File: rtl/plab5_mcore_mem_resp_queue_sep.sv
// plab5_mcore_mem_resp_queue_sep: 2-entry response FIFO whose ready depends only on registered state
module plab5_mcore_mem_resp_queue_sep #(
  parameter int p_nbits = 1
) (
  input  logic               clk,
  input  logic               rst_n_i,
  input  logic               enq_val_i,
  output logic               enq_rdy_o,
  input  logic [p_nbits-1:0] enq_msg_i,
  output logic               deq_val_o,
  input  logic               deq_rdy_i,
  output logic [p_nbits-1:0] deq_msg_o
);
  logic [p_nbits-1:0] ent_q [2];
  logic [1:0] count_q, count_d;
  logic wr_ptr_q, rd_ptr_q, enq, deq;
  assign enq_rdy_o = rst_n_i && (count_q != 2'd2);
  assign deq_val_o = count_q != 2'd0;
  assign deq_msg_o = ent_q[rd_ptr_q];
  assign enq       = enq_val_i && enq_rdy_o;
  assign deq       = deq_val_o && deq_rdy_i;
  assign count_d   = count_q + {1'b0, enq} - {1'b0, deq};
  // storage and pointers; reset drops any in-flight responses and zeroes the head
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      ent_q[0] <= '0;
      ent_q[1] <= '0;
    end else begin
      count_q <= count_d;
      if (enq) begin
        ent_q[wr_ptr_q] <= enq_msg_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (deq) rd_ptr_q <= ~rd_ptr_q;
    end
  end
endmodule

// File: rtl/plab5_mcore_mem_bank_sep.sv
// plab5_mcore_mem_bank_sep: word-array memory bank with high/low partition and split ctrl/data responses
module plab5_mcore_mem_bank_sep
  import plab5_mcore_mem_bank_pkg::*;
#(
  parameter int p_mem_opaque_nbits = 8,
  parameter int p_mem_addr_nbits   = 32,
  parameter int p_mem_data_nbits   = 32,
  parameter int p_num_entries      = 256
) (
  input  logic                                                    clk,
  input  logic                                                    reset,
  input  logic                                                    mode,
  input  logic [rqc_nbits(p_mem_opaque_nbits, p_mem_addr_nbits)-1:0] req_msg_control,
  input  logic [p_mem_data_nbits-1:0]                             req_msg_data,
  input  logic                                                    req_val,
  output logic                                                    req_rdy,
  input  logic                                                    req_domain,
  output logic [rsc_nbits(p_mem_opaque_nbits)-1:0]                resp_msg_control,
  output logic [p_mem_data_nbits-1:0]                             resp_msg_data,
  output logic                                                    resp_val,
  input  logic                                                    resp_rdy,
  output logic                                                    resp_domain
);
  localparam int O  = p_mem_opaque_nbits;
  localparam int A  = p_mem_addr_nbits;
  localparam int D  = p_mem_data_nbits;
  localparam int IW = $clog2(p_num_entries);
  localparam int RSC = rsc_nbits(O);
  localparam int QW = 1 + RSC + D;
  logic [D-1:0] mem_q [p_num_entries];
  logic [2:0] req_type;
  logic [O-1:0] req_opaque;
  logic [A-1:0] req_addr;
  logic [1:0] req_len;
  logic [IW-1:0] idx;
  logic [D-1:0] mask, rd_data;
  logic viol, is_wr, req_fire, unused_addr;
  assign {req_type, req_opaque, req_addr, req_len} = req_msg_control;
  assign idx         = req_addr[BYTE_OFF_NBITS +: IW];
  assign unused_addr = ^{req_addr[A-1:BYTE_OFF_NBITS+IW], req_addr[BYTE_OFF_NBITS-1:0]};
  assign mask        = len_mask(req_len);
  assign req_fire    = req_val && req_rdy;
  assign is_wr       = (req_type == MEM_WRITE) || (req_type == MEM_INIT);
  assign viol        = mode && (req_domain == DOM_LOW) && idx[IW-1] && (req_type != MEM_INIT);
  assign rd_data     = (req_type == MEM_READ && !viol) ? (mem_q[idx] & mask) : '0;
  // byte-masked array write at acceptance; blocked writes still produce a response
  always_ff @(posedge clk) begin
    if (req_fire && is_wr && !viol) mem_q[idx] <= (mem_q[idx] & ~mask) | (req_msg_data & mask);
  end
  plab5_mcore_mem_resp_queue_sep #(.p_nbits(QW)) u_resp_q (
    .clk       (clk),
    .rst_n_i   (reset),
    .enq_val_i (req_val),
    .enq_rdy_o (req_rdy),
    .enq_msg_i ({req_domain, req_type, req_opaque, req_len, rd_data}),
    .deq_val_o (resp_val),
    .deq_rdy_i (resp_rdy),
    .deq_msg_o ({resp_domain, resp_msg_control, resp_msg_data})
  );
endmodule

// File: tb/tb_plab5_mcore_mem_bank_sep.sv
// tb_plab5_mcore_mem_bank_sep: directed scoreboard bench for the domain-tagged memory bank
module tb_plab5_mcore_mem_bank_sep;
  localparam logic [2:0] RD = 3'd0, WR = 3'd1, IN = 3'd2;
  logic clk = 1'b0, reset = 1'b0, mode = 1'b0, req_val = 1'b0, resp_rdy = 1'b0, req_domain = 1'b0;
  logic [44:0] req_msg_control = '0;
  logic [31:0] req_msg_data = '0;
  logic req_rdy, resp_val, resp_domain;
  logic [12:0] resp_msg_control;
  logic [31:0] resp_msg_data;
  int checks = 0, errors = 0, last_waits = 0;
  logic [45:0] exp_q [$];

  always #5 clk = ~clk;

  plab5_mcore_mem_bank_sep dut (
    .clk(clk), .reset(reset), .mode(mode),
    .req_msg_control(req_msg_control), .req_msg_data(req_msg_data),
    .req_val(req_val), .req_rdy(req_rdy), .req_domain(req_domain),
    .resp_msg_control(resp_msg_control), .resp_msg_data(resp_msg_data),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_domain(resp_domain)
  );

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2:0] t, input logic [7:0] op, input logic [31:0] a,
                      input logic [1:0] len, input logic [31:0] d, input logic dom,
                      input logic [31:0] exp_d);
    req_msg_control = {t, op, a, len};
    req_msg_data    = d;
    req_domain      = dom;
    req_val         = 1'b1;
    last_waits      = 0;
    @(negedge clk);
    while (!req_rdy && last_waits < 50) begin
      last_waits++;
      @(negedge clk);
    end
    chk("req_accept", req_rdy, 1);
    if (req_rdy) exp_q.push_back({dom, t, op, len, exp_d});
    @(posedge clk);
    #1 req_val = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset && resp_val && resp_rdy) begin
      chk("sb_nonempty", 64'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("resp", {resp_domain, resp_msg_control, resp_msg_data}, exp_q.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_resp_val", resp_val, 0);
    chk("rst_req_rdy", req_rdy, 0);
    chk("rst_resp_ctrl", resp_msg_control, 0);
    chk("rst_resp_data", resp_msg_data, 0);
    chk("rst_resp_dom", resp_domain, 0);
    reset = 1'b1;
    idle(1);
    chk("rdy_after_rst", req_rdy, 1);
    mode = 1'b1;
    resp_rdy = 1'b1;
    send(WR, 8'h11, 32'h200, 2'd0, 32'hDEADBEEF, 1'b1, 32'h0);
    idle(2);
    chk("idle_resp_val", resp_val, 0);
    send(RD, 8'h22, 32'h200, 2'd0, 32'h0, 1'b1, 32'hDEADBEEF);
    chk("lat1_val", resp_val, 1);
    chk("lat1_data", resp_msg_data, 32'hDEADBEEF);
    chk("lat1_dom", resp_domain, 1);
    chk("lat1_ctrl", resp_msg_control, {RD, 8'h22, 2'd0});
    send(RD, 8'h23, 32'h200, 2'd0, 32'h0, 1'b0, 32'h0);
    send(WR, 8'h24, 32'h200, 2'd0, 32'h11111111, 1'b0, 32'h0);
    send(RD, 8'h25, 32'h200, 2'd0, 32'h0, 1'b1, 32'hDEADBEEF);
    mode = 1'b0;
    send(RD, 8'h26, 32'h200, 2'd0, 32'h0, 1'b0, 32'hDEADBEEF);
    send(WR, 8'h27, 32'h200, 2'd0, 32'h11111111, 1'b0, 32'h0);
    send(RD, 8'h28, 32'h200, 2'd0, 32'h0, 1'b0, 32'h11111111);
    mode = 1'b1;
    send(IN, 8'h29, 32'h204, 2'd0, 32'h22222222, 1'b0, 32'h0);
    send(RD, 8'h2A, 32'h204, 2'd0, 32'h0, 1'b1, 32'h22222222);
    send(WR, 8'h2B, 32'h1FC, 2'd0, 32'h0BADF00D, 1'b0, 32'h0);
    send(RD, 8'h2C, 32'h1FC, 2'd0, 32'h0, 1'b0, 32'h0BADF00D);
    send(3'd5, 8'h51, 32'h200, 2'd0, 32'h0, 1'b1, 32'h0);
    send(WR, 8'h61, 32'h0, 2'd0, 32'hAABBCCDD, 1'b0, 32'h0);
    send(WR, 8'h62, 32'h0, 2'd1, 32'h000000EE, 1'b0, 32'h0);
    send(RD, 8'h63, 32'h0, 2'd0, 32'h0, 1'b0, 32'hAABBCCEE);
    send(RD, 8'h64, 32'h0, 2'd2, 32'h0, 1'b0, 32'h0000CCEE);
    send(RD, 8'h65, 32'h3, 2'd3, 32'h0, 1'b0, 32'h00BBCCEE);
    send(RD, 8'h66, 32'h400, 2'd0, 32'h0, 1'b0, 32'hAABBCCEE);
    idle(2);
    resp_rdy = 1'b0;
    send(RD, 8'h31, 32'h200, 2'd0, 32'h0, 1'b1, 32'h11111111);
    send(RD, 8'h32, 32'h0, 2'd0, 32'h0, 1'b1, 32'hAABBCCEE);
    chk("bp_full_rdy", req_rdy, 0);
    req_msg_control = {RD, 8'h33, 32'h204, 2'd0};
    req_domain = 1'b1;
    req_val = 1'b1;
    idle(2);
    chk("bp_hold_rdy", req_rdy, 0);
    chk("bp_hold_data", resp_msg_data, 32'h11111111);
    chk("bp_hold_ctrl", resp_msg_control, {RD, 8'h31, 2'd0});
    resp_rdy = 1'b1;
    send(RD, 8'h33, 32'h204, 2'd0, 32'h0, 1'b1, 32'h22222222);
    chk("bp_third_wait", last_waits, 1);
    for (int i = 0; i < 16; i++) begin
      send(RD, 8'(8'h70 + i), (i % 2) ? 32'h0 : 32'h200, 2'd0, 32'h0, 1'b1,
           (i % 2) ? 32'hAABBCCEE : 32'h11111111);
      chk("stream_wait", last_waits, 0);
      chk("stream_val", resp_val, 1);
    end
    idle(2);
    resp_rdy = 1'b0;
    send(WR, 8'h41, 32'h8, 2'd0, 32'h12345678, 1'b1, 32'h0);
    send(WR, 8'h42, 32'hC, 2'd0, 32'h55AA55AA, 1'b1, 32'h0);
    chk("pre_rst_full", req_rdy, 0);
    reset = 1'b0;
    #1;
    chk("rst_async_val", resp_val, 0);
    chk("rst_async_rdy", req_rdy, 0);
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b1;
    idle(1);
    chk("rst_rel_rdy", req_rdy, 1);
    chk("rst_rel_val", resp_val, 0);
    resp_rdy = 1'b1;
    send(RD, 8'h43, 32'h8, 2'd0, 32'h0, 1'b1, 32'h12345678);
    send(RD, 8'h44, 32'hC, 2'd0, 32'h0, 1'b1, 32'h55AA55AA);
    idle(3);
    chk("sb_drained", 64'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
